// File: rtl/ram_access_arbiter.sv
// Two-port arbiter in front of a single-port registered-read RAM.
// Serialises port 0 (CPU) and port 1 (video/IO) accesses; one-cycle ack per access.
module ram_access_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              last_grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic              winner_q, winner_d;
  logic              we_q, we_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              last_grant_q, last_grant_d;

  logic              grant_vld;
  logic              grant_id;

  // prio_q names the port that wins a tie; it is the port not granted last.
  always_comb begin
    grant_vld = m0_req | m1_req;
    if (FIXED_PRIO != 0) begin
      grant_id = ~m0_req;
    end else if (m0_req && m1_req) begin
      grant_id = prio_q;
    end else begin
      grant_id = ~m0_req;
    end
  end

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    we_d          = we_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = ram_wren_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    last_grant_d  = last_grant_q;

    case (state_q)
      IDLE: begin
        ram_wren_d = 1'b0;
        if (grant_vld) begin
          winner_d      = grant_id;
          last_grant_d  = grant_id;
          prio_d        = ~grant_id;
          we_d          = grant_id ? m1_we : m0_we;
          ram_address_d = grant_id ? m1_addr : m0_addr;
          ram_data_d    = grant_id ? m1_wdata : m0_wdata;
          ram_wren_d    = grant_id ? m1_we : m0_we;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        ram_wren_d = 1'b0;
        cnt_d      = CNT_LOAD;
        if (we_q) begin
          m0_ack_d = ~winner_q;
          m1_ack_d = winner_q;
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (winner_q) begin
            m1_rdata_d = ram_q;
          end else begin
            m0_rdata_d = ram_q;
          end
          m0_ack_d = ~winner_q;
          m1_ack_d = winner_q;
          state_d  = DONE;
        end
      end
      default: begin
        // Requests are deliberately ignored here so a held req cannot double-grant.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      winner_q      <= 1'b0;
      we_q          <= 1'b0;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      last_grant_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      we_q          <= we_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign last_grant  = last_grant_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: three instances (round-robin, fixed priority, read latency 2)
// share stimulus; each owns a behavioural RAM. Acks are matched against a scoreboard queue.
module tb_ram_access_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  logic        a_m0_ack, a_m1_ack, a_ram_wren, a_busy, a_last_grant;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_ram_address, a_ram_data, a_ram_q;
  logic        b_m0_ack, b_m1_ack, b_ram_wren, b_busy, b_last_grant;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_ram_address, b_ram_data, b_ram_q;
  logic        c_m0_ack, c_m1_ack, c_ram_wren, c_busy, c_last_grant;
  logic [15:0] c_m0_rdata, c_m1_rdata, c_ram_address, c_ram_data, c_ram_q, c_ram_q1;

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .ram_address(a_ram_address), .ram_data(a_ram_data), .ram_wren(a_ram_wren),
    .ram_q(a_ram_q), .busy(a_busy), .last_grant(a_last_grant));

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1), .FIXED_PRIO(1)) dut_b (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .ram_address(b_ram_address), .ram_data(b_ram_data), .ram_wren(b_ram_wren),
    .ram_q(b_ram_q), .busy(b_busy), .last_grant(b_last_grant));

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(2), .FIXED_PRIO(0)) dut_c (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(c_m0_ack), .m0_rdata(c_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(c_m1_ack), .m1_rdata(c_m1_rdata),
    .ram_address(c_ram_address), .ram_data(c_ram_data), .ram_wren(c_ram_wren),
    .ram_q(c_ram_q), .busy(c_busy), .last_grant(c_last_grant));

  // Behavioural single-port RAMs with registered read of the given latency.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] mem_c [0:65535];
  always @(posedge clock) begin
    if (a_ram_wren) mem_a[a_ram_address] <= a_ram_data;
    a_ram_q <= mem_a[a_ram_address];
    if (b_ram_wren) mem_b[b_ram_address] <= b_ram_data;
    b_ram_q <= mem_b[b_ram_address];
    if (c_ram_wren) mem_c[c_ram_address] <= c_ram_data;
    c_ram_q1 <= mem_c[c_ram_address];
    c_ram_q  <= c_ram_q1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  ackv;
    logic        chk_rd;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Selects which instance the ack scoreboard watches.
  int          sel = 0;
  logic [1:0]  ackv;
  logic [15:0] rd;
  always_comb begin
    ackv = {a_m1_ack, a_m0_ack};
    rd   = a_m1_ack ? a_m1_rdata : a_m0_rdata;
    if (sel == 1) begin
      ackv = {b_m1_ack, b_m0_ack};
      rd   = b_m1_ack ? b_m1_rdata : b_m0_rdata;
    end else if (sel == 2) begin
      ackv = {c_m1_ack, c_m0_ack};
      rd   = c_m1_ack ? c_m1_rdata : c_m0_rdata;
    end
  end

  task automatic set_port(input int p, input logic r, input logic we,
                          input logic [15:0] addr, input logic [15:0] wd);
    if (p == 0) begin
      m0_req = r; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = r; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  task automatic do_reset;
    @(posedge clock); #1;
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clock);
    checks++; if ({a_busy, a_m0_ack, a_m1_ack, a_ram_wren, a_last_grant} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {a_busy, a_m0_ack, a_m1_ack, a_ram_wren, a_last_grant});
    end
    checks++; if ({a_m0_rdata, a_m1_rdata} !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got %h expected 00000000", {a_m0_rdata, a_m1_rdata});
    end
    checks++; if ({a_ram_address, a_ram_data} !== 32'h0) begin
      fails++; $display("FAIL reset_ram: got %h expected 00000000", {a_ram_address, a_ram_data});
    end
  endtask

  task automatic test_write;
    int          wp [3] = '{0, 1, 0};
    logic [15:0] wa [3] = '{16'h0001, 16'h0010, 16'h0000};
    logic [15:0] wd [3] = '{16'h0003, 16'hBEEF, 16'h0000};
    int t0;
    exp_t e;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      set_port(wp[i], 1'b1, 1'b1, wa[i], wd[i]);
      @(negedge clock); t0 = cyc;
      sb.push_back('{t0 + 2, (wp[i] == 1) ? 2'b10 : 2'b01, 1'b0, 16'h0});
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        if (k == 1) begin
          checks++; if ({a_ram_wren, a_ram_address, a_ram_data} !== {1'b1, wa[i], wd[i]}) begin
            fails++; $display("FAIL write_issue%0d: got wren %b addr %h data %h expected 1 %h %h",
                              i, a_ram_wren, a_ram_address, a_ram_data, wa[i], wd[i]);
          end
        end
        if (k == 2) begin
          checks++; if (a_ram_wren !== 1'b0) begin
            fails++; $display("FAIL write_wren_drop%0d: got %b expected 0", i, a_ram_wren);
          end
        end
        if (ackv !== 2'b00) begin
          checks++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL write_unexpected_ack: cyc %0d ack %b, none expected", cyc, ackv);
          end else begin
            e = sb.pop_front();
            if (ackv !== e.ackv || cyc != e.cyc) begin
              fails++; $display("FAIL write_ack%0d: got cyc %0d ack %b expected cyc %0d ack %b", i, cyc, ackv, e.cyc, e.ackv);
            end
          end
          set_port(wp[i], 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
      checks++; if (sb.size() != 0) begin
        fails++; $display("FAIL write_missing_ack%0d: %0d outstanding expected 0", i, sb.size()); sb.delete();
      end
    end
  endtask

  task automatic test_read;
    int t0;
    logic wren_seen;
    exp_t e;
    sel = 0; wren_seen = 1'b0;
    @(posedge clock); #1;
    set_port(0, 1'b1, 1'b0, 16'h0001, 16'h0);
    @(negedge clock); t0 = cyc;
    sb.push_back('{t0 + 3, 2'b01, 1'b1, 16'h0003});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (a_ram_wren) wren_seen = 1'b1;
      if (ackv !== 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL read_unexpected_ack: cyc %0d ack %b", cyc, ackv);
        end else begin
          e = sb.pop_front();
          if (ackv !== e.ackv || cyc != e.cyc || rd !== e.rdata) begin
            fails++; $display("FAIL read_ack: got cyc %0d ack %b rdata %h expected cyc %0d ack %b rdata %h",
                              cyc, ackv, rd, e.cyc, e.ackv, e.rdata);
          end
        end
        set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      if (k == 5) begin
        checks++; if ({a_busy, a_m0_rdata} !== {1'b0, 16'h0003}) begin
          fails++; $display("FAIL read_hold: got busy %b rdata %h expected 0 0003", a_busy, a_m0_rdata);
        end
      end
    end
    checks++; if (wren_seen !== 1'b0) begin
      fails++; $display("FAIL read_wren: got %b expected 0", wren_seen);
    end
    checks++; if (sb.size() != 0) begin
      fails++; $display("FAIL read_missing_ack: %0d outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  // Both ports reading continuously; p selects the instance (0 round-robin, 1 fixed priority).
  task automatic test_contention(input int p);
    int t0;
    exp_t e;
    logic exp_lg;
    do_reset();
    sel = p;
    @(posedge clock); #1;
    set_port(0, 1'b1, 1'b0, 16'h0001, 16'h0);
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clock); t0 = cyc;
    if (p == 0) begin
      sb.push_back('{t0 + 3,  2'b01, 1'b1, 16'h0003});
      sb.push_back('{t0 + 7,  2'b10, 1'b1, 16'hBEEF});
      sb.push_back('{t0 + 11, 2'b01, 1'b1, 16'h0003});
      sb.push_back('{t0 + 15, 2'b10, 1'b1, 16'hBEEF});
    end else begin
      sb.push_back('{t0 + 3,  2'b01, 1'b1, 16'h0003});
      sb.push_back('{t0 + 7,  2'b01, 1'b1, 16'h0003});
      sb.push_back('{t0 + 11, 2'b01, 1'b1, 16'h0003});
      sb.push_back('{t0 + 15, 2'b10, 1'b1, 16'hBEEF});
    end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      if (k == 5 || k == 9 || k == 13) begin
        if (p == 0) exp_lg = (k == 5 || k == 13);
        else        exp_lg = (k == 13);
        checks++; if (((p == 0) ? a_last_grant : b_last_grant) !== exp_lg) begin
          fails++; $display("FAIL contention%0d_last_grant_k%0d: got %b expected %b",
                            p, k, (p == 0) ? a_last_grant : b_last_grant, exp_lg);
        end
      end
      if (ackv !== 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL contention%0d_unexpected_ack: cyc %0d ack %b", p, cyc, ackv);
        end else begin
          e = sb.pop_front();
          if (ackv !== e.ackv || cyc != e.cyc || rd !== e.rdata) begin
            fails++; $display("FAIL contention%0d_ack: got cyc %0d ack %b rdata %h expected cyc %0d ack %b rdata %h",
                              p, cyc, ackv, rd, e.cyc, e.ackv, e.rdata);
          end
        end
      end
      if (p == 1 && k == 11) m0_req = 1'b0;
      if (k == 15) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    checks++; if (sb.size() != 0) begin
      fails++; $display("FAIL contention%0d_missing_ack: %0d outstanding expected 0", p, sb.size()); sb.delete();
    end
  endtask

  task automatic test_latency2;
    logic [15:0] ra [2] = '{16'h0000, 16'h0010};
    logic [15:0] rv [2] = '{16'h0000, 16'hBEEF};
    int t0;
    exp_t e;
    do_reset();
    sel = 2;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      set_port(0, 1'b1, 1'b0, ra[i], 16'h0);
      @(negedge clock); t0 = cyc;
      sb.push_back('{t0 + 4, 2'b01, 1'b1, rv[i]});
      for (int k = 1; k <= 5; k++) begin
        @(negedge clock);
        if (i == 0) begin
          checks++; if (c_busy !== (k <= 4)) begin
            fails++; $display("FAIL lat2_busy_k%0d: got %b expected %b", k, c_busy, (k <= 4));
          end
        end
        if (ackv !== 2'b00) begin
          checks++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL lat2_unexpected_ack: cyc %0d ack %b", cyc, ackv);
          end else begin
            e = sb.pop_front();
            if (ackv !== e.ackv || cyc != e.cyc || rd !== e.rdata) begin
              fails++; $display("FAIL lat2_ack%0d: got cyc %0d ack %b rdata %h expected cyc %0d ack %b rdata %h",
                                i, cyc, ackv, rd, e.cyc, e.ackv, e.rdata);
            end
          end
          set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
      checks++; if (sb.size() != 0) begin
        fails++; $display("FAIL lat2_missing_ack%0d: %0d outstanding expected 0", i, sb.size()); sb.delete();
      end
    end
  endtask

  task automatic test_reset_mid_access;
    int t0;
    exp_t e;
    do_reset();
    sel = 0;
    @(posedge clock); #1;
    set_port(1, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    checks++; if (a_busy !== 1'b1 || a_m1_ack !== 1'b0) begin
      fails++; $display("FAIL midreset_wait: got busy %b ack %b expected 1 0", a_busy, a_m1_ack);
    end
    reset = 1'b1;
    set_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    checks++; if ({a_busy, a_m0_ack, a_m1_ack, a_ram_wren, a_last_grant} !== 5'b0) begin
      fails++; $display("FAIL midreset_ctrl: got %b expected 00000", {a_busy, a_m0_ack, a_m1_ack, a_ram_wren, a_last_grant});
    end
    checks++; if ({a_ram_address, a_m0_rdata, a_m1_rdata} !== 48'h0) begin
      fails++; $display("FAIL midreset_data: got %h expected 0", {a_ram_address, a_m0_rdata, a_m1_rdata});
    end
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 16'h0001, 16'h0);
    t0 = cyc;
    sb.push_back('{t0 + 3, 2'b01, 1'b1, 16'h0003});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (ackv !== 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL midreset_unexpected_ack: cyc %0d ack %b", cyc, ackv);
        end else begin
          e = sb.pop_front();
          if (ackv !== e.ackv || cyc != e.cyc || rd !== e.rdata) begin
            fails++; $display("FAIL midreset_ack: got cyc %0d ack %b rdata %h expected cyc %0d ack %b rdata %h",
                              cyc, ackv, rd, e.cyc, e.ackv, e.rdata);
          end
        end
        set_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    checks++; if (sb.size() != 0) begin
      fails++; $display("FAIL midreset_missing_ack: %0d outstanding expected 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention(0);
    test_contention(1);
    test_latency2();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Shares the single-port 16-bit RAM (address, clock, data, wren, q; registered read) between two requesters. Port 0 is the processor data path and port 1 is the video/IO fetch path. The block serialises their accesses and drives the RAM control pins. It delivers read data and a one-cycle acknowledge back to the requester that issued the access.

Parameters:
ADDR_W, 16, width of RAM address and requester addresses
DATA_W, 16, width of RAM data words
RD_LATENCY, 1, clock edges from RAM address sample to valid q (legal values ≥1)
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
m0_req  in  1  port 0 access request; held until m0_ack
m0_we  in  1  port 0 access type: 1 = write, 0 = read
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_ack  out  1  one-cycle completion pulse for port 0
m0_rdata  out  DATA_W  port 0 read data; valid when m0_ack is high
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1
ram_address  out  ADDR_W  to RAM address
ram_data  out  DATA_W  to RAM data
ram_wren  out  1  to RAM wren
ram_q  in  DATA_W  from RAM q
busy  out  1  high in every state except IDLE
last_grant  out  1  id of the most recently granted port

Behaviour:
- Reset clears all outputs to 0: state = IDLE, acks = 0, rdata = 0, ram_address = 0, ram_data = 0, ram_wren = 0, last_grant = 0, RR pointer favours port 0. Reset is sampled on the rising edge and overrides every other event.
- Requester contract: while req is high, the requester holds we/addr/wdata stable. A requester may keep req high after its ack to start a new access.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - With no request, the state stays IDLE, ram_wren = 0, and ram_address/ram_data hold their previous values.
  - If any req is high, the block picks a winner and registers the winner's addr/wdata into ram_address/ram_data. It also registers ram_wren = winner we, records the winner, updates last_grant, and moves to ISSUE.
- Arbitration:
  - FIXED_PRIO = 0: a lone requester wins. If both request, the port not granted last wins (after reset, port 0).
  - FIXED_PRIO = 1: port 0 always wins when it requests.
- ISSUE: lasts exactly 1 cycle and the RAM samples at its closing edge. ram_wren is high only in this cycle, and only for writes. The transition registers ram_wren = 0 and loads the wait counter with RD_LATENCY-1.
- WAIT:
  - Writes skip WAIT and go straight to DONE.
  - Reads stay in WAIT while the counter is non-zero, decrementing it each cycle.
  - At zero, the block captures ram_q into the winner's rdata register and moves to DONE.
- DONE: the winner's ack is high for exactly 1 cycle; the other port's ack stays 0. The next state is IDLE. Requests are not sampled in DONE, which prevents a double grant from a still-high req.
- Timing when req is sampled in IDLE in cycle t:
  - ram_* are valid in cycle t+1.
  - A write acks in cycle t+2.
  - A read acks in cycle t+2+RD_LATENCY, which is t+3 at default.
  - The earliest new grant is the cycle after ack.
- mX_rdata holds its value until that port's next read completes. Writes never change rdata.
- A req that drops before its grant is ignored. A req that drops after its grant does not cancel the access; ack is still issued.
- Reset mid-access: no ack is issued and the state returns to IDLE. A write already sampled by the RAM remains in memory.
- Widths are equal throughout, so no truncation or extension is needed.

Test Plan:
1. Port 0 write, addr 0x0001, data 0x0003:
   - ram_wren = 1 for exactly cycle t+1, with ram_address = 0x0001 and ram_data = 0x0003.
   - m0_ack = 1 in cycle t+2 only.
2. Port 0 read, addr 0x0001, after test 1:
   - m0_ack = 1 in cycle t+3 with m0_rdata = 0x0003.
   - ram_wren stays 0 and m1_ack stays 0.
3. Both ports hold read req continuously after reset, FIXED_PRIO = 0:
   - Grants alternate 0,1,0,1 (last_grant = 0,1,0,1).
   - Each ack is exactly 1 cycle wide, with ack-to-ack spacing of 4 cycles.
4. Same stimulus as test 3 with FIXED_PRIO = 1:
   - Only port 0 is acked.
   - Dropping m0_req lets port 1 be granted in the next IDLE cycle.
5. RD_LATENCY = 2, read of addr 0x0000 holding 0x0000:
   - ack at t+4 and rdata = 0x0000.
   - busy is high in cycles t+1..t+4.
6. Assert reset during WAIT of a port 1 read:
   - No m1_ack is issued.
   - The next cycle shows all outputs at 0 and the state is IDLE.
   - A new port 0 request is then served normally.
